// File: rtl/alu_pkg.sv
// Shared ALU constants and types used by the result mux and the write-back
// demux: data width, number of result sources/destinations, select width,
// and the state encoding of the single-entry write-back stage.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_NSRC  = 10;
    localparam int unsigned ALU_SELW  = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_t;

    // One-hot decode of a source/destination index; out-of-range indices give 0.
    function automatic logic [ALU_NSRC-1:0] sel_to_onehot(input logic [ALU_SELW-1:0] sel);
        logic [ALU_NSRC-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < ALU_NSRC; i++) begin
            if (sel == ALU_SELW'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/alu_demux_wb.sv
// ALU result write-back demux: a single-entry registered stage that takes one
// ALU result plus a destination select and presents it to exactly one of
// NDEST destinations with a valid/ready handshake on both sides.
// Illegal selects are accepted, dropped and flagged; completed deliveries are
// counted for bring-up.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready depends on out_ready)
//   in_data, in_sel       ALU result and destination index
//   out_data              held result, broadcast to all destinations
//   out_valid             one-hot per-destination valid
//   out_ready             per-destination accept
//   err, err_sel          sticky illegal-select flag and first bad select
//   err_clr               synchronous clear of err/err_sel
//   delivered_cnt         wrapping count of completed deliveries
module alu_demux_wb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned NDEST = ALU_NSRC,
    parameter int unsigned SELW  = ALU_SELW,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  in_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [NDEST-1:0] out_valid,
    input  logic [NDEST-1:0] out_ready,
    output logic             err,
    output logic [SELW-1:0]  err_sel,
    input  logic             err_clr,
    output logic [CNTW-1:0]  delivered_cnt
);

    wb_state_t        state;
    wb_state_t        state_next;
    logic [SELW-1:0]  sel_q;
    logic             acc;
    logic             dlv;
    logic             sel_legal;
    logic             load;
    logic             bad;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. out_valid is decoded from the held
    // select rather than registered, so reset clears it immediately and it
    // can never be multi-hot.
    always_comb begin
        out_valid  = '0;
        state_next = state;
        for (int unsigned d = 0; d < NDEST; d++) begin
            if (state == FULL && sel_q == SELW'(d)) begin
                out_valid[d] = 1'b1;
            end
        end
        // Only the selected destination's ready can complete a delivery.
        dlv       = |(out_valid & out_ready);
        in_ready  = (state == EMPTY) || dlv;
        acc       = in_valid && in_ready;
        sel_legal = 32'(in_sel) < NDEST;
        load      = acc && sel_legal;
        bad       = acc && !sel_legal;
        if (load) begin
            state_next = FULL;
        end else if (dlv) begin
            state_next = EMPTY;
        end
    end

    // Datapath, error capture and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= '0;
            sel_q         <= '0;
            err           <= 1'b0;
            err_sel       <= '0;
            delivered_cnt <= '0;
        end else begin
            if (load) begin
                out_data <= in_data;
                sel_q    <= in_sel;
            end
            // A new illegal select beats a simultaneous clear; the clear
            // also re-arms capture of the select value.
            if (bad) begin
                err <= 1'b1;
                if (!err || err_clr) begin
                    err_sel <= in_sel;
                end
            end else if (err_clr) begin
                err     <= 1'b0;
                err_sel <= '0;
            end
            if (dlv) begin
                delivered_cnt <= delivered_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_demux_wb.sv
// Directed self-checking bench for alu_demux_wb. Inputs change 1 ns after a
// rising edge and outputs are checked 2 ns after the edge.
module tb_alu_demux_wb;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_sel;
    logic [31:0] out_data;
    logic [9:0]  out_valid;
    logic [9:0]  out_ready;
    logic        err;
    logic [3:0]  err_sel;
    logic        err_clr;
    logic [15:0] delivered_cnt;

    int checks = 0;
    int errors = 0;

    alu_demux_wb #(
        .WIDTH(32),
        .NDEST(10),
        .SELW (4),
        .CNTW (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err          (err),
        .err_sel      (err_sel),
        .err_clr      (err_clr),
        .delivered_cnt(delivered_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
        out_ready = '0; err_clr = 1'b0;
        #12;
        checks++;
        if (out_valid !== 10'h000 || out_data !== 32'h0 || err !== 1'b0 ||
            err_sel !== 4'h0 || delivered_cnt !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%h data=%h err=%b err_sel=%h cnt=%0d rdy=%b want 000/0/0/0/0/1",
                     out_valid, out_data, err, err_sel, delivered_cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step();
        in_valid = 1'b1; in_data = 32'habcdefab; in_sel = 4'd0; out_ready = '1;
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 10'h001 || out_data !== 32'habcdefab) begin
            errors++;
            $display("FAIL single_out: valid=%h data=%h want 001/abcdefab", out_valid, out_data);
        end
        step();
        #1;
        checks++;
        if (delivered_cnt !== 16'd1 || out_valid !== 10'h000) begin
            errors++;
            $display("FAIL single_cnt: cnt=%0d valid=%h want 1/000", delivered_cnt, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 32'h0f0f0f0f; in_sel = 4'd1; out_ready = '1;
        step();
        in_data = 32'hffffffff; in_sel = 4'd8;
        #1;
        checks++;
        if (out_valid !== 10'h002 || out_data !== 32'h0f0f0f0f || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%h data=%h rdy=%b want 002/0f0f0f0f/1",
                     out_valid, out_data, in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 10'h100 || out_data !== 32'hffffffff || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: valid=%h data=%h rdy=%b want 100/ffffffff/1",
                     out_valid, out_data, in_ready);
        end
        step();
        #1;
        // One delivery from the single-word test plus two here.
        checks++;
        if (delivered_cnt !== 16'd3 || out_valid !== 10'h000) begin
            errors++;
            $display("FAIL b2b_cnt: cnt=%0d valid=%h want 3/000", delivered_cnt, out_valid);
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 32'h12345678; in_sel = 4'd3; out_ready = '0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 10'h008 || out_data !== 32'h12345678 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%h data=%h rdy=%b want 008/12345678/0",
                         i, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 10'h020;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_other_ready: rdy=%b want 0", in_ready);
        end
        step();
        #1;
        checks++;
        if (out_valid !== 10'h008 || delivered_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_other_hold: valid=%h cnt=%0d want 008/3", out_valid, delivered_cnt);
        end
        out_ready = 10'h008;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_rdy: rdy=%b want 1", in_ready);
        end
        step();
        #1;
        checks++;
        if (out_valid !== 10'h000 || delivered_cnt !== 16'd4 || out_data !== 32'h12345678) begin
            errors++;
            $display("FAIL stall_release: valid=%h cnt=%0d data=%h want 000/4/12345678",
                     out_valid, delivered_cnt, out_data);
        end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_data = 32'h55555555; in_sel = 4'd12; out_ready = '1;
        step();
        in_sel = 4'd15;
        #1;
        checks++;
        if (out_valid !== 10'h000 || err !== 1'b1 || err_sel !== 4'd12) begin
            errors++;
            $display("FAIL illegal_first: valid=%h err=%b err_sel=%0d want 000/1/12",
                     out_valid, err, err_sel);
        end
        step();
        in_valid = 1'b0; err_clr = 1'b1;
        #1;
        checks++;
        if (out_valid !== 10'h000 || err !== 1'b1 || err_sel !== 4'd12) begin
            errors++;
            $display("FAIL illegal_second: valid=%h err=%b err_sel=%0d want 000/1/12",
                     out_valid, err, err_sel);
        end
        step();
        in_valid = 1'b1; in_sel = 4'd13;
        #1;
        checks++;
        if (err !== 1'b0 || err_sel !== 4'd0) begin
            errors++;
            $display("FAIL illegal_clear: err=%b err_sel=%0d want 0/0", err, err_sel);
        end
        step();
        in_sel = 4'd14;
        #1;
        checks++;
        if (err !== 1'b1 || err_sel !== 4'd13) begin
            errors++;
            $display("FAIL illegal_clr_set: err=%b err_sel=%0d want 1/13", err, err_sel);
        end
        // Clear while err is already set and another bad select arrives.
        step();
        in_valid = 1'b0; err_clr = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1 || err_sel !== 4'd14 || delivered_cnt !== 16'd4 || out_valid !== 10'h000) begin
            errors++;
            $display("FAIL illegal_reclr: err=%b err_sel=%0d cnt=%0d valid=%h want 1/14/4/000",
                     err, err_sel, delivered_cnt, out_valid);
        end
    endtask

    task automatic test_reset_midop();
        in_valid = 1'b1; in_data = 32'hdeadbeef; in_sel = 4'd2; out_ready = '0;
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 10'h004 || out_data !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL midop_full: valid=%h data=%h want 004/deadbeef", out_valid, out_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 10'h000 || out_data !== 32'h0 || delivered_cnt !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: valid=%h data=%h cnt=%0d err=%b want 000/0/0/0",
                     out_valid, out_data, delivered_cnt, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        step();
        in_valid = 1'b1; in_data = 32'h00000001; in_sel = 4'd9; out_ready = '1;
        // 65535 accepts at one per cycle; the last one delivers the cycle after.
        repeat (65535) @(posedge clk);
        #1;
        in_valid = 1'b0;
        step();
        #1;
        checks++;
        if (delivered_cnt !== 16'd65535 || out_valid !== 10'h000) begin
            errors++;
            $display("FAIL wrap_max: cnt=%0d valid=%h want 65535/000", delivered_cnt, out_valid);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #1;
        checks++;
        if (delivered_cnt !== 16'd0) begin
            errors++;
            $display("FAIL wrap_zero: cnt=%0d want 0", delivered_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_reset_midop();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_demux_wb.md
Name: alu_demux_wb

Overview:
Inverse of the ALU result mux: takes one 32-bit ALU result plus a 4-bit destination select and delivers it to exactly one of 10 destination ports (indices 0..9, same numbering as the mux sources).
Single-entry registered stage with valid/ready handshake on both sides, so a stalled destination back-pressures the ALU.
Illegal selects are absorbed and flagged; a delivery counter supports bring-up and debug.

Parameters:
WIDTH, 32, data width of result and destination bus
NDEST, 10, number of destination ports
SELW, 4, select width; must satisfy 2**SELW >= NDEST
CNTW, 16, width of delivered-word counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU result valid
in_ready  out  1  block can accept a result this cycle
in_data  in  WIDTH  ALU result
in_sel  in  SELW  destination index
out_data  out  WIDTH  held result, broadcast to all destinations
out_valid  out  NDEST  one-hot; bit d set when the held word targets destination d
out_ready  in  NDEST  per-destination accept
err  out  1  sticky: illegal select seen
err_sel  out  SELW  first illegal select value captured
err_clr  in  1  synchronous clear of err/err_sel
delivered_cnt  out  CNTW  number of completed deliveries, wraps

Behaviour:
- States: EMPTY, FULL. Reset (rst_n low, async) -> EMPTY; out_data=0, out_valid=0, err=0, err_sel=0, delivered_cnt=0. A held word is discarded by reset mid-operation.
- Accept: acc = in_valid & in_ready. Deliver: dlv = FULL & out_ready[sel_q].
- in_ready = EMPTY | dlv (combinational from out_ready; enables back-to-back flow at 1 word/cycle).
- Legal select (in_sel < NDEST) on acc: next cycle out_data=in_data, sel_q=in_sel, state FULL, out_valid = 1<<in_sel. Latency in->out is 1 cycle.
- Illegal select (in_sel >= NDEST) on acc: word accepted and dropped; does not enter FULL (a concurrent dlv still empties the stage); err<=1; err_sel<=in_sel only if err was 0 (first captured).
- FULL, no dlv: out_data, out_valid, sel_q held stable; in_ready=0.
- FULL with dlv and legal acc in the same cycle: stays FULL with the new word; delivered_cnt+1.
- FULL with dlv, no acc: -> EMPTY, out_valid=0, out_data keeps its last value.
- out_ready bits of non-selected destinations are ignored.
- delivered_cnt increments by 1 per dlv and wraps from 2**CNTW-1 to 0.
- err_clr: err<=0, err_sel<=0. If err_clr and an illegal acc occur in the same cycle, set wins (err=1, err_sel=new value).
- out_valid is never multi-hot.

Decomposition:
- Shared package alu_pkg: ALU_WIDTH=32, ALU_NSRC=10, ALU_SELW=4 constants (shared with the mux), enum wb_state_t {EMPTY, FULL}.
- No sub-module needed. Optional: a one-hot decoder function sel_to_onehot in alu_pkg, reusable by the mux.

Test Plan:
- Reset, then send 0xabcdefab sel 0 with out_ready all ones -> one cycle later out_valid=0x001, out_data=0xabcdefab; delivered_cnt=1 the following cycle.
- Back-to-back 0x0f0f0f0f sel 1, then 0xffffffff sel 8, out_ready all ones -> out_valid 0x002 then 0x100 on consecutive cycles, in_ready held 1, cnt=2.
- Stall: 0x12345678 sel 3 with out_ready[3]=0 for 4 cycles -> out_valid=0x008 and data stable, in_ready=0; raise out_ready[3] -> in_ready=1 the same cycle, FULL->EMPTY next cycle, cnt+1. Raising out_ready[5] alone has no effect.
- Illegal: sel 12, then sel 15 -> no out_valid, err=1, err_sel=12 (not 15); err_clr -> err=0; err_clr together with sel 13 -> err=1, err_sel=13.
- Reset mid-op: hold a FULL word on sel 2 with out_ready=0, pulse rst_n low asynchronously between clock edges -> out_valid=0, out_data=0 immediately; cnt=0.
- Wrap: force/drive 65535 deliveries (CNTW=16), then 1 more -> delivered_cnt=0.
